opamp_loop_sequencer: RTL and testbench

Per-sample sequencer for the op-amp feedback loop. It generates the loop sample strobe from the system clock and time-shares one external IEEE-754 multiplier between the gain product and the filter-output square. It then commits both results to the filter input and feedback registers with a single-cycle strobe. It replaces the divided-clock register stage with a single-clock, enable-strobed schedule.

---
 rtl/opamp_pkg.sv | 40 ++++
 rtl/opamp_tick_gen.sv | 36 +++
 rtl/opamp_loop_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_opamp_loop_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opamp_pkg.sv
// Shared types and constants for the op-amp feedback loop sequencer:
// FSM state encoding, gain table, setpoint thresholds and reset values.
package opamp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_G = 3'd1,
    ST_WAIT_G  = 3'd2,
    ST_ISSUE_S = 3'd3,
    ST_WAIT_S  = 3'd4,
    ST_COMMIT  = 3'd5
  } state_e;

  // IEEE-754 single-precision gains: 270.0, 100.0, 50.0, 10.0
  localparam logic [31:0] GAIN_LE_100  = 32'h43870000;
  localparam logic [31:0] GAIN_LE_500  = 32'h42C80000;
  localparam logic [31:0] GAIN_MID     = 32'h42480000;
  localparam logic [31:0] GAIN_GE_2400 = 32'h41200000;

  localparam logic [31:0] THR_LOW  = 32'd100;
  localparam logic [31:0] THR_MID  = 32'd500;
  localparam logic [31:0] THR_HIGH = 32'd2400;

  localparam logic [39:0] MUL_OUT_RESET = 40'h3F80000000;

  function automatic logic [31:0] gain_select(input logic [31:0] setpoint);
    logic [31:0] gain;
    if (setpoint <= THR_LOW) begin
      gain = GAIN_LE_100;
    end else if (setpoint <= THR_MID) begin
      gain = GAIN_LE_500;
    end else if (setpoint >= THR_HIGH) begin
      gain = GAIN_GE_2400;
    end else begin
      gain = GAIN_MID;
    end
    return gain;
  endfunction

endpackage

// File: rtl/opamp_tick_gen.sv
// Loop sample tick generator: counts 0..TICK_DIV-1 while enabled and flags
// the last count; held at zero while disabled.
module opamp_tick_gen
  import opamp_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] count_r;

  // sample-period counter, cleared the cycle after enable drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= CNT_ZERO;
    end else if (!enable) begin
      count_r <= CNT_ZERO;
    end else if (count_r == CNT_LAST) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign tick = enable & (count_r == CNT_LAST);

endmodule

// File: rtl/opamp_loop_sequencer.sv
// Per-sample loop sequencer: time-shares one multiplier between the gain
// product and the filter-output square, then commits both with one strobe.
module opamp_loop_sequencer
  import opamp_pkg::*;
#(
  parameter int C_WIDTH  = 16,
  parameter int TICK_DIV = 1000,
  parameter int MUL_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [C_WIDTH-1:0] non_inv,
  input  logic [32:0]        sum,
  input  logic [39:0]        filter_out,
  output logic [39:0]        mul_a,
  output logic [39:0]        mul_b,
  output logic               mul_start,
  input  logic [71:0]        mul_result,
  output logic [39:0]        mul_out,
  output logic [71:0]        square,
  output logic               sample_tick,
  output logic               busy,
  output logic               overrun
);

  localparam int WCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MUL_LAT - 1);
  localparam logic [WCW-1:0] WAIT_ZERO = WCW'(0);
  localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

  logic               tick_s;
  state_e             state_r;
  state_e             next_state_s;
  logic [WCW-1:0]     wait_cnt_r;
  logic               wait_done_s;
  logic               snap_load_s;
  logic [C_WIDTH-1:0] non_inv_snap_r;
  logic [32:0]        sum_snap_r;
  logic [39:0]        filter_snap_r;
  logic [39:0]        pend_gain_r;
  logic [C_WIDTH-1:0] non_inv_src_s;
  logic [32:0]        sum_src_s;
  logic [39:0]        mul_a_s;
  logic [39:0]        mul_b_s;
  logic               mul_start_s;
  logic [39:0]        mul_a_r;
  logic [39:0]        mul_b_r;
  logic               mul_start_r;
  logic [39:0]        mul_out_r;
  logic [71:0]        square_r;
  logic               sample_tick_r;
  logic               busy_r;
  logic               overrun_r;

  opamp_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick_s)
  );

  assign wait_done_s = (wait_cnt_r == WAIT_LAST);
  assign snap_load_s = (state_r == ST_IDLE) & tick_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:    if (tick_s) next_state_s = ST_ISSUE_G; else next_state_s = ST_IDLE;
      ST_ISSUE_G: next_state_s = ST_WAIT_G;
      ST_WAIT_G:  if (wait_done_s) next_state_s = ST_ISSUE_S; else next_state_s = ST_WAIT_G;
      ST_ISSUE_S: next_state_s = ST_WAIT_S;
      ST_WAIT_S:  if (wait_done_s) next_state_s = ST_COMMIT; else next_state_s = ST_WAIT_S;
      ST_COMMIT:  next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // multiplier latency counter, running only in the wait states
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r <= WAIT_ZERO;
    end else if (((state_r == ST_WAIT_G) || (state_r == ST_WAIT_S)) && !wait_done_s) begin
      wait_cnt_r <= wait_cnt_r + WAIT_ONE;
    end else begin
      wait_cnt_r <= WAIT_ZERO;
    end
  end

  // FSM output logic: values for the next cycle, so outputs leave a register.
  // The gain issue is entered straight from IDLE, so it forwards the live
  // inputs that are being snapshotted in the same edge.
  always_comb begin
    non_inv_src_s = snap_load_s ? non_inv : non_inv_snap_r;
    sum_src_s     = snap_load_s ? sum : sum_snap_r;
    mul_a_s       = 40'h0;
    mul_b_s       = 40'h0;
    mul_start_s   = 1'b0;
    case (next_state_s)
      ST_ISSUE_G: begin
        mul_a_s     = {gain_select(32'(non_inv_src_s)), 8'h00};
        mul_b_s     = {sum_src_s, 7'b0000000};
        mul_start_s = 1'b1;
      end
      ST_ISSUE_S: begin
        mul_a_s     = filter_snap_r;
        mul_b_s     = filter_snap_r;
        mul_start_s = 1'b1;
      end
      ST_WAIT_G, ST_WAIT_S: begin
        mul_a_s = mul_a_r;
        mul_b_s = mul_b_r;
      end
      default: begin
        mul_a_s     = 40'h0;
        mul_b_s     = 40'h0;
        mul_start_s = 1'b0;
      end
    endcase
  end

  // input snapshot taken when a tick starts a new sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      non_inv_snap_r <= '0;
      sum_snap_r     <= 33'h0;
      filter_snap_r  <= 40'h0;
    end else if (snap_load_s) begin
      non_inv_snap_r <= non_inv;
      sum_snap_r     <= sum;
      filter_snap_r  <= filter_out;
    end
  end

  // result capture; the square lands directly in its committed register so
  // both products are visible in the same cycle as sample_tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_gain_r <= 40'h0;
      mul_out_r   <= MUL_OUT_RESET;
      square_r    <= 72'h0;
    end else begin
      if ((state_r == ST_WAIT_G) && wait_done_s) begin
        pend_gain_r <= mul_result[71:32];
      end
      if ((state_r == ST_WAIT_S) && wait_done_s) begin
        mul_out_r <= pend_gain_r;
        square_r  <= mul_result;
      end
    end
  end

  // registered outputs; overrun is sticky until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_a_r       <= 40'h0;
      mul_b_r       <= 40'h0;
      mul_start_r   <= 1'b0;
      sample_tick_r <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      mul_a_r       <= mul_a_s;
      mul_b_r       <= mul_b_s;
      mul_start_r   <= mul_start_s;
      sample_tick_r <= (next_state_s == ST_COMMIT);
      busy_r        <= (next_state_s != ST_IDLE);
      overrun_r     <= overrun_r | (tick_s & (state_r != ST_IDLE));
    end
  end

  assign mul_a       = mul_a_r;
  assign mul_b       = mul_b_r;
  assign mul_start   = mul_start_r;
  assign mul_out     = mul_out_r;
  assign square      = square_r;
  assign sample_tick = sample_tick_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_opamp_loop_sequencer.sv
// Bench for opamp_loop_sequencer: two instances (normal and overrunning tick
// rate) checked every cycle against a per-sample event model.
module tb_opamp_loop_sequencer;

  localparam int NI   = 2;
  localparam int TD_A = 10;
  localparam int TD_B = 6;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] non_inv;
  logic [32:0] sum;
  logic [39:0] filter_out;
  logic [71:0] mul_result_i [NI];
  logic [39:0] mul_a_o [NI];
  logic [39:0] mul_b_o [NI];
  logic        mul_start_o [NI];
  logic [39:0] mul_out_o [NI];
  logic [71:0] square_o [NI];
  logic        sample_tick_o [NI];
  logic        busy_o [NI];
  logic        overrun_o [NI];

  always #5 clk = ~clk;

  opamp_loop_sequencer #(.C_WIDTH(16), .TICK_DIV(TD_A), .MUL_LAT(LAT)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .non_inv(non_inv), .sum(sum),
    .filter_out(filter_out), .mul_a(mul_a_o[0]), .mul_b(mul_b_o[0]),
    .mul_start(mul_start_o[0]), .mul_result(mul_result_i[0]), .mul_out(mul_out_o[0]),
    .square(square_o[0]), .sample_tick(sample_tick_o[0]), .busy(busy_o[0]),
    .overrun(overrun_o[0]));

  opamp_loop_sequencer #(.C_WIDTH(16), .TICK_DIV(TD_B), .MUL_LAT(LAT)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .non_inv(non_inv), .sum(sum),
    .filter_out(filter_out), .mul_a(mul_a_o[1]), .mul_b(mul_b_o[1]),
    .mul_start(mul_start_o[1]), .mul_result(mul_result_i[1]), .mul_out(mul_out_o[1]),
    .square(square_o[1]), .sample_tick(sample_tick_o[1]), .busy(busy_o[1]),
    .overrun(overrun_o[1]));

  // one accepted sample at cycle acc_t fixes every output for the next 3+2L cycles
  typedef struct {
    int          td;
    int          lat;
    int          acc_t;
    logic [31:0] gain;
    logic [39:0] b_op;
    logic [39:0] filt;
    logic [71:0] res_g;
    logic [71:0] res_s;
    logic [39:0] c_out;
    logic [71:0] c_sq;
    bit          ov;
    int          run_start;
    bit          prev_en;
  } mdl_t;

  typedef struct {
    logic [15:0] ni;
    logic [31:0] gain;
  } gvec_t;

  mdl_t  m [NI];
  gvec_t tbl [7];
  int    n;
  int    checks = 0;
  int    errors = 0;
  bit    fixed_res = 1'b0;
  int    starts_a[$];
  int    ticks_a[$];

  function automatic logic [31:0] ref_gain(input int v);
    if (v <= 100) return 32'h43870000;
    else if (v <= 500) return 32'h42C80000;
    else if (v >= 2400) return 32'h41200000;
    else return 32'h42480000;
  endfunction

  function automatic logic [71:0] rnd72();
    return {$urandom, $urandom, 8'($urandom)};
  endfunction

  task automatic chk(input string nm, input int k, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d: got %h want %h", nm, k, n, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0d want %0d", nm, n, act, exp);
    end
  endtask

  task automatic mdl_reset(input int k);
    m[k].acc_t     = -1000;
    m[k].c_out     = 40'h3F80000000;
    m[k].c_sq      = 72'h0;
    m[k].ov        = 1'b0;
    m[k].prev_en   = 1'b0;
    m[k].run_start = 0;
  endtask

  task automatic mdl_compare(input int k);
    int          d;
    int          l;
    logic [39:0] ea;
    logic [39:0] eb;
    l = m[k].lat;
    d = n - m[k].acc_t;
    if (d == 3 + 2 * l) begin
      m[k].c_out = m[k].res_g[71:32];
      m[k].c_sq  = m[k].res_s;
    end
    ea = 40'h0;
    eb = 40'h0;
    if (d >= 1 && d <= 1 + l) begin
      ea = {m[k].gain, 8'h00};
      eb = m[k].b_op;
    end else if (d >= 2 + l && d <= 2 + 2 * l) begin
      ea = m[k].filt;
      eb = m[k].filt;
    end
    chk("mul_a", k, 72'(mul_a_o[k]), 72'(ea));
    chk("mul_b", k, 72'(mul_b_o[k]), 72'(eb));
    chk("mul_start", k, 72'(mul_start_o[k]), 72'(d == 1 || d == 2 + l));
    chk("sample_tick", k, 72'(sample_tick_o[k]), 72'(d == 3 + 2 * l));
    chk("busy", k, 72'(busy_o[k]), 72'(d >= 1 && d <= 3 + 2 * l));
    chk("overrun", k, 72'(overrun_o[k]), 72'(m[k].ov));
    chk("mul_out", k, 72'(mul_out_o[k]), 72'(m[k].c_out));
    chk("square", k, square_o[k], m[k].c_sq);
  endtask

  task automatic mdl_tick(input int k);
    bit tk;
    int d;
    if (enable && !m[k].prev_en) m[k].run_start = n;
    m[k].prev_en = enable;
    tk = enable && ((n - m[k].run_start) % m[k].td == m[k].td - 1);
    d = n - m[k].acc_t;
    if (tk) begin
      if (d >= 1 && d <= 3 + 2 * m[k].lat) begin
        m[k].ov = 1'b1;
      end else begin
        m[k].acc_t = n;
        m[k].gain  = ref_gain(int'(non_inv));
        m[k].b_op  = {sum, 7'b0000000};
        m[k].filt  = filter_out;
        m[k].res_g = fixed_res ? {9{8'hAA}} : rnd72();
        m[k].res_s = fixed_res ? {9{8'h55}} : rnd72();
      end
    end
    d = n - m[k].acc_t;
    if (d == 1 + m[k].lat) mul_result_i[k] = m[k].res_g;
    else if (d == 2 + 2 * m[k].lat) mul_result_i[k] = m[k].res_s;
    else mul_result_i[k] = rnd72();
  endtask

  // called at the negedge of cycle n: check outputs, drive inputs, advance
  task automatic do_cycle(input bit en, input logic [15:0] ni, input logic [32:0] sm,
                          input logic [39:0] fo);
    for (int k = 0; k < NI; k++) mdl_compare(k);
    if (mul_start_o[0]) starts_a.push_back(n);
    if (sample_tick_o[0]) ticks_a.push_back(n);
    enable = en;
    non_inv = ni;
    sum = sm;
    filter_out = fo;
    for (int k = 0; k < NI; k++) mdl_tick(k);
    @(negedge clk);
    n++;
  endtask

  task automatic rand_cycle(input bit en);
    logic [15:0] ni;
    case ($urandom_range(0, 6))
      0: ni = 16'd100;
      1: ni = 16'd101;
      2: ni = 16'd500;
      3: ni = 16'd2399;
      4: ni = 16'd2400;
      default: ni = 16'($urandom_range(0, 65535));
    endcase
    do_cycle(en, ni, {1'($urandom), $urandom}, {$urandom, 8'($urandom)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    int t0;
    int e0;
    tbl[0] = '{16'd100,   32'h43870000};
    tbl[1] = '{16'd101,   32'h42C80000};
    tbl[2] = '{16'd500,   32'h42C80000};
    tbl[3] = '{16'd2399,  32'h42480000};
    tbl[4] = '{16'd2400,  32'h41200000};
    tbl[5] = '{16'd0,     32'h43870000};
    tbl[6] = '{16'd65535, 32'h41200000};

    reset_n = 1'b0;
    enable = 1'b0;
    non_inv = 16'd0;
    sum = 33'h0;
    filter_out = 40'h0;
    for (int k = 0; k < NI; k++) begin
      mul_result_i[k] = 72'h0;
      m[k].td  = (k == 0) ? TD_A : TD_B;
      m[k].lat = LAT;
      mdl_reset(k);
    end
    n = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) mdl_compare(k);
    reset_n = 1'b1;
    n = 0;

    // first sample after reset: issues at 10 and 13, commit at 16
    repeat (20) do_cycle(1'b1, 16'd300, 33'h1_2345_6789, 40'h12_3456_789A);
    chk_i("first_start", starts_a.size() > 0 ? starts_a[0] : -1, 10);
    chk_i("second_start", starts_a.size() > 1 ? starts_a[1] : -1, 13);
    chk_i("first_commit", ticks_a.size() > 0 ? ticks_a[0] : -1, 16);

    // gain selection table
    for (int i = 0; i < 7; i++) begin
      t0 = m[0].acc_t;
      guard = 0;
      while (m[0].acc_t == t0 && guard < 40) begin
        do_cycle(1'b1, tbl[i].ni, {1'($urandom), $urandom}, {$urandom, 8'($urandom)});
        guard++;
      end
      if (m[0].acc_t == t0) chk_i("gain_tbl_timeout", guard, 0);
      else chk("gain_tbl", 0, 72'(mul_a_o[0][39:8]), 72'(tbl[i].gain));
    end

    // fixed multiplier patterns reach the committed registers
    fixed_res = 1'b1;
    repeat (25) rand_cycle(1'b1);
    chk("pattern_mul_out", 0, 72'(mul_out_o[0]), 72'(40'hAAAAAAAAAA));
    chk("pattern_square", 0, square_o[0], 72'h555555555555555555);
    fixed_res = 1'b0;
    repeat (3) rand_cycle(1'b1);
    chk("pattern_hold", 0, 72'(mul_out_o[0]), 72'(40'hAAAAAAAAAA));

    // enable dropped in WAIT_G: sequence completes, nothing new starts
    guard = 0;
    while ((n - m[0].acc_t) != 2 && guard < 40) begin
      rand_cycle(1'b1);
      guard++;
    end
    chk_i("reach_wait_g", n - m[0].acc_t, 2);
    starts_a.delete();
    ticks_a.delete();
    repeat (30) rand_cycle(1'b0);
    chk_i("drop_commits", ticks_a.size(), 1);
    chk_i("drop_starts", starts_a.size(), 1);
    e0 = n;
    starts_a.delete();
    repeat (15) rand_cycle(1'b1);
    chk_i("reenable_start", starts_a.size() > 0 ? starts_a[0] : -1, e0 + TD_A);

    // randomized traffic with occasional enable drops
    repeat (300) rand_cycle($urandom_range(0, 19) != 0);

    // reset pulse in WAIT_S: immediate reset values, no late commit
    guard = 0;
    while ((n - m[0].acc_t) != 3 + LAT && guard < 60) begin
      rand_cycle(1'b1);
      guard++;
    end
    chk_i("reach_wait_s", n - m[0].acc_t, 3 + LAT);
    chk("ov_before_reset", 1, 72'(overrun_o[1]), 72'(1'b1));
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      mdl_reset(k);
      mdl_compare(k);
    end
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    ticks_a.delete();
    repeat (12) rand_cycle(1'b1);
    chk_i("no_commit_after_reset", ticks_a.size(), 0);
    repeat (40) rand_cycle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
